// File: rtl/sobel_result_writer_if.sv
// Result-stream and output-buffer write bus of the Sobel result writer.
// The slave modport is the writer itself; master is the producer/memory side.
interface sobel_result_writer_if #(
  parameter int CNT_W = 17
);
  logic             start;
  logic [31:0]      out_start_addr;
  logic             result_valid;
  logic [7:0]       result_data;
  logic             result_ready;
  logic             mem_write;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             mem_ack;
  logic             frame_done;
  logic [CNT_W-1:0] pixel_count;

  modport master (
    output start, out_start_addr, result_valid, result_data, mem_ack,
    input  result_ready, mem_write, mem_addr, mem_wdata, frame_done, pixel_count
  );

  modport slave (
    input  start, out_start_addr, result_valid, result_data, mem_ack,
    output result_ready, mem_write, mem_addr, mem_wdata, frame_done, pixel_count
  );
endinterface

// File: rtl/sobel_result_writer.sv
// Serpentine-order write sequencer: one acknowledged byte write per Sobel result,
// row_base advanced by addition, frame_done after NUM_COLS*NUM_ROWS writes.
module sobel_result_writer #(
  parameter int NUM_COLS   = 160,
  parameter int NUM_ROWS   = 478,
  parameter int ROW_STRIDE = 160,
  parameter int CNT_W      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_result_writer_if.slave  bus
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [31:0]      STRIDE   = 32'(ROW_STRIDE);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEPT = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] STEP   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             dir;
  logic [31:0]      row_base;
  logic [31:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] count_q;
  logic             row_end;

  // With NUM_COLS=1 both ends coincide, so dir toggles every row.
  always_comb begin
    row_end = dir ? (col == '0) : (col == COL_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      dir      <= 1'b0;
      row_base <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      count_q  <= '0;
    end else if (bus.start) begin
      // Restart takes priority over any handshake in flight.
      state    <= ACCEPT;
      row_base <= bus.out_start_addr;
      col      <= '0;
      row      <= '0;
      dir      <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        ACCEPT: begin
          if (bus.result_valid) begin
            wdata_q <= bus.result_data;
            addr_q  <= row_base + 32'(col);
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            count_q <= count_q + CNT_W'(1);
            state   <= STEP;
          end
        end
        STEP: begin
          if (row_end && row == ROW_LAST) begin
            state <= DONE;
          end else if (row_end) begin
            row      <= row + ROW_W'(1);
            row_base <= row_base + STRIDE;
            dir      <= ~dir;
            state    <= ACCEPT;
          end else begin
            col   <= dir ? col - COL_W'(1) : col + COL_W'(1);
            state <= ACCEPT;
          end
        end
        IDLE, DONE: state <= state;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_ready = (state == ACCEPT);
  assign bus.mem_write    = (state == WRITE);
  assign bus.frame_done   = (state == DONE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.pixel_count  = count_q;

endmodule

// File: tb/tb_sobel_result_writer.sv
// Directed bench for sobel_result_writer on a 4x3 frame with stride 8.
module tb_sobel_result_writer;

  localparam int NC = 4;
  localparam int NR = 3;
  localparam int ST = 8;
  localparam int CW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  sobel_result_writer_if #(.CNT_W(CW)) bus ();

  sobel_result_writer #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .ROW_STRIDE(ST), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_ack) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serpentine address of pixel n in a frame starting at base.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int n);
    int r, c;
    r = n / NC;
    c = n % NC;
    if (r % 2 == 1) c = NC - 1 - c;
    return base + 32'(r * ST) + 32'(c);
  endfunction

  task automatic pulse_start(input logic [31:0] a);
    bus.start = 1'b1;
    bus.out_start_addr = a;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at a negedge with the DUT in ACCEPT; returns one cycle after STEP.
  task automatic do_write(input logic [31:0] a, input logic [7:0] d,
                          input int unsigned dly, input logic [31:0] cnt);
    check("ready_accept", 32'(bus.result_ready), 32'd1);
    bus.result_valid = 1'b1;
    bus.result_data  = d;
    @(negedge clk);
    bus.result_valid = 1'b0;
    check("mem_write", 32'(bus.mem_write), 32'd1);
    check("mem_addr", bus.mem_addr, a);
    check("mem_wdata", 32'(bus.mem_wdata), 32'(d));
    check("ready_write", 32'(bus.result_ready), 32'd0);
    for (int unsigned i = 0; i < dly; i++) begin
      @(negedge clk);
      check("wait_write", 32'(bus.mem_write), 32'd1);
      check("wait_addr", bus.mem_addr, a);
      check("wait_wdata", 32'(bus.mem_wdata), 32'(d));
      check("wait_ready", 32'(bus.result_ready), 32'd0);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("step_write", 32'(bus.mem_write), 32'd0);
    check("pixel_count", 32'(bus.pixel_count), cnt);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base_cnt;
    bus.start = 1'b0;
    bus.out_start_addr = '0;
    bus.result_valid = 1'b0;
    bus.result_data = '0;
    bus.mem_ack = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.result_ready), 32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_count", 32'(bus.pixel_count), 32'd0);
    rst = 1'b0;

    // Valid without start: nothing happens.
    bus.result_valid = 1'b1;
    bus.result_data = 8'h55;
    repeat (8) begin
      @(negedge clk);
      check("nostart_ready", 32'(bus.result_ready), 32'd0);
      check("nostart_write", 32'(bus.mem_write), 32'd0);
      check("nostart_count", 32'(bus.pixel_count), 32'd0);
    end
    bus.result_valid = 1'b0;

    // Full frame, immediate ack; addresses listed explicitly for the first rows.
    pulse_start(32'h1000);
    do_write(32'h1000, 8'h10, 0, 1);
    do_write(32'h1001, 8'h11, 0, 2);
    do_write(32'h1002, 8'h12, 0, 3);
    do_write(32'h1003, 8'h13, 0, 4);
    do_write(32'h100B, 8'h14, 0, 5);
    do_write(32'h100A, 8'h15, 0, 6);
    do_write(32'h1009, 8'h16, 0, 7);
    do_write(32'h1008, 8'h17, 0, 8);
    do_write(32'h1010, 8'h18, 0, 9);
    do_write(32'h1011, 8'h19, 0, 10);
    do_write(32'h1012, 8'h1A, 0, 11);
    do_write(32'h1013, 8'h1B, 0, 12);
    check("done_flag", 32'(bus.frame_done), 32'd1);
    check("done_count", 32'(bus.pixel_count), 32'd12);
    check("done_ready", 32'(bus.result_ready), 32'd0);

    // Results after frame_done are ignored.
    base_cnt = wr_count;
    bus.mem_ack = 1'b1;
    repeat (3) begin
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
      @(negedge clk);
      check("post_done_write", 32'(bus.mem_write), 32'd0);
      check("post_done_flag", 32'(bus.frame_done), 32'd1);
    end
    bus.mem_ack = 1'b0;
    check("post_done_writes", 32'(wr_count - base_cnt), 32'd0);
    check("post_done_count", 32'(bus.pixel_count), 32'd12);

    // New frame at 0x2000.
    pulse_start(32'h2000);
    check("restart_done", 32'(bus.frame_done), 32'd0);
    check("restart_count", 32'(bus.pixel_count), 32'd0);
    do_write(32'h2000, 8'hA5, 0, 1);

    // Full frame with 3-cycle ack latency.
    pulse_start(32'h1000);
    base_cnt = wr_count;
    for (int n = 0; n < NC * NR; n++)
      do_write(exp_addr(32'h1000, n), 8'(8'h10 + n), 3, 32'(n + 1));
    check("slow_writes", 32'(wr_count - base_cnt), 32'd12);
    check("slow_done", 32'(bus.frame_done), 32'd1);

    // start while the sixth write (0x100A) is pending.
    pulse_start(32'h1000);
    for (int n = 0; n < 5; n++)
      do_write(exp_addr(32'h1000, n), 8'(n), 0, 32'(n + 1));
    bus.result_valid = 1'b1;
    bus.result_data = 8'h66;
    @(negedge clk);
    bus.result_valid = 1'b0;
    check("abort_addr", bus.mem_addr, 32'h100A);
    check("abort_write_before", 32'(bus.mem_write), 32'd1);
    pulse_start(32'h3000);
    check("abort_write_after", 32'(bus.mem_write), 32'd0);
    check("abort_count", 32'(bus.pixel_count), 32'd0);
    do_write(32'h3000, 8'h77, 0, 1);

    // start together with result_valid: start wins, nothing consumed.
    bus.result_valid = 1'b1;
    bus.result_data = 8'h99;
    pulse_start(32'h4000);
    bus.result_valid = 1'b0;
    check("start_vs_valid_write", 32'(bus.mem_write), 32'd0);
    check("start_vs_valid_ready", 32'(bus.result_ready), 32'd1);
    do_write(32'h4000, 8'h42, 0, 1);

    // Reset in the middle of a write.
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    check("pre_rst_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_write", 32'(bus.mem_write), 32'd0);
    check("mid_rst_ready", 32'(bus.result_ready), 32'd0);
    check("mid_rst_done", 32'(bus.frame_done), 32'd0);
    check("mid_rst_count", 32'(bus.pixel_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.result_valid = 1'b1;
    bus.mem_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ready", 32'(bus.result_ready), 32'd0);
      check("post_rst_write", 32'(bus.mem_write), 32'd0);
    end
    bus.result_valid = 1'b0;
    bus.mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_result_writer.md
Name: sobel_result_writer

Overview:
Write-side address generator and memory-write sequencer for the Sobel pipeline. It is the counterpart of the window-read slider: it accepts one edge-magnitude byte per window position, in serpentine scan order, and writes it to the output image buffer. It walks rows left-to-right, then right-to-left, and so on. It issues one acknowledged write per result and flags frame completion.

Parameters:
NUM_COLS, 160, output pixels per row
NUM_ROWS, 478, output rows per frame
ROW_STRIDE, 160, byte distance between consecutive output rows
CNT_W, 17, width of pixel_count (must hold NUM_COLS*NUM_ROWS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: latch out_start_addr, clear counters, begin frame
out_start_addr  in  32  byte address of output pixel (row 0, col 0)
result_valid  in  1  result_data holds a valid magnitude
result_data  in  8  edge magnitude for the current window position
result_ready  out  1  block accepts result_data this cycle
mem_write  out  1  write request to output buffer
mem_addr  out  32  write byte address
mem_wdata  out  8  write data
mem_ack  in  1  memory accepted the write this cycle
frame_done  out  1  all NUM_COLS*NUM_ROWS results written
pixel_count  out  CNT_W  number of completed writes this frame

Behaviour:
- Reset values (asynchronous, on rst=1): state IDLE; result_ready=0; mem_write=0; mem_addr=0; mem_wdata=0; frame_done=0; pixel_count=0; col=0; row=0; dir=0 (rightward); row_base=0.
- All outputs are registered or decoded directly from state/registers. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: result_ready=0. On start, go to ACCEPT with row_base=out_start_addr, col=0, row=0, dir=0, pixel_count=0, frame_done=0.
  - ACCEPT: result_ready=1. If result_valid, capture result_data into mem_wdata and row_base+col into mem_addr, then go to WRITE.
  - WRITE: mem_write=1; mem_addr and mem_wdata held stable. Stays in WRITE until mem_ack=1. In the mem_ack cycle, increment pixel_count and go to STEP.
  - STEP: one cycle; result_ready=0, mem_write=0. Update position:
    - dir=0 and col<NUM_COLS-1: col+1.
    - dir=1 and col>0: col-1.
    - dir=0 and col=NUM_COLS-1: row+1, row_base+=ROW_STRIDE, dir=1, col unchanged.
    - dir=1 and col=0: row+1, row_base+=ROW_STRIDE, dir=0, col unchanged.
    - If row=NUM_ROWS-1 and at the row end for the current dir, go to DONE with no row increment. Otherwise go to ACCEPT.
  - DONE: frame_done=1, result_ready=0, held until start or rst. On start, restart as from IDLE.
- Throughput: at least 3 cycles per result (ACCEPT, WRITE with immediate ack, STEP).
- Arithmetic: address = row_base + col, 32-bit, wraps modulo 2^32. There are no multipliers; row_base advances by addition only.
- Boundaries:
  - mem_ack outside WRITE is ignored.
  - result_valid outside ACCEPT is ignored; data is not consumed.
  - start in any state restarts the frame on the next cycle. A start during WRITE drops mem_write the next cycle and abandons that write without incrementing pixel_count.
  - start and result_valid in the same cycle: start wins; the data is not consumed and result_ready is not considered handshaken.
  - NUM_COLS=1: each row is one pixel; dir toggles every row.
  - rst asserted mid-write drops mem_write immediately.

Test Plan:
- Params NUM_COLS=4, NUM_ROWS=3, ROW_STRIDE=8; start with out_start_addr=0x1000; 12 results data=0x10..0x1B; mem_ack same cycle -> write addresses 0x1000,0x1001,0x1002,0x1003, then 0x100B,0x100A,0x1009,0x1008, then 0x1010..0x1013 with matching data. frame_done=1 after 12th ack; pixel_count=12.
- Same setup, mem_ack delayed 3 cycles on every write -> mem_write/mem_addr/mem_wdata stable across the wait. Exactly 12 writes, no duplicates; result_ready low during waits.
- result_valid asserted continuously from reset, no start -> result_ready=0, mem_write=0, pixel_count=0 indefinitely.
- start pulse while in WRITE at pixel 5 (addr 0x100A) -> mem_write drops next cycle. Frame restarts; next write address is the new out_start_addr with pixel_count=1 after its ack.
- rst asserted in WRITE -> mem_write, result_ready, frame_done, pixel_count all 0 in the same cycle. Block stays IDLE until start.
- After frame_done, further result_valid pulses -> no writes; a new start with addr 0x2000 clears frame_done and the first write goes to 0x2000.
